// File: rtl/screen_reader.sv
// Frame scanner: fetches screen RAM words in ascending address order and
// streams them out one pixel at a time over a valid/ready handshake.
module screen_reader #(
  parameter int W   = 16,
  parameter int AW  = 13,
  parameter int WPR = 32
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rdata,
  output logic          pix,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          line_end,
  output logic          frame_end,
  output logic          busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(W - 1);
  localparam logic [CW-1:0] NEXT_TO_LAST_PIX = CW'(W - 2);
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [W-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          row_last;
  logic          frame_last;

  assign row_last   = (addr % AW'(WPR)) == AW'(WPR - 1);
  assign frame_last = (addr == LAST_ADDR);
  assign mem_addr   = addr;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      sreg      <= '0;
      cnt       <= '0;
      mem_rd    <= 1'b0;
      pix       <= 1'b0;
      pix_valid <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= FETCH;
            addr   <= '0;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        FETCH: begin
          mem_rd <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          sreg      <= mem_rdata;
          cnt       <= '0;
          pix       <= mem_rdata[0];
          pix_valid <= 1'b1;
          line_end  <= 1'b0;
          frame_end <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready) begin
            sreg <= sreg >> 1;
            cnt  <= cnt + 1'b1;
            pix  <= sreg[1];
            if (cnt == LAST_PIX) begin
              pix_valid <= 1'b0;
              line_end  <= 1'b0;
              frame_end <= 1'b0;
              if (frame_last) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                addr   <= addr + 1'b1;
                mem_rd <= 1'b1;
                state  <= FETCH;
              end
            end else begin
              // flags are registered, so look one pixel ahead
              line_end  <= (cnt == NEXT_TO_LAST_PIX) && row_last;
              frame_end <= (cnt == NEXT_TO_LAST_PIX) && frame_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_reader.sv
// Scoreboard bench for screen_reader on a reduced 32-word screen with
// randomized RAM contents and consumer back-pressure.
module tb_screen_reader;

  localparam int W = 16;
  localparam int AW = 5;
  localparam int WPR = 4;
  localparam int NW = 1 << AW;

  logic          clk50m = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic          pix;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic          line_end;
  logic          frame_end;
  logic          busy;

  screen_reader #(.W(W), .AW(AW), .WPR(WPR)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .start(start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix(pix), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .line_end(line_end), .frame_end(frame_end), .busy(busy)
  );

  always #5 clk50m = ~clk50m;

  typedef struct packed {logic p; logic le; logic fe;} exp_t;

  logic [W-1:0] ram [NW];
  exp_t         pq[$];
  int           aq[$];
  int           checks = 0;
  int           errors = 0;
  int           ready_mode = 0;
  int           n_rd, n_xfer, n_le, n_fe, busy_cycles;
  logic         stall_prev = 1'b0;
  logic         sp, sle, sfe;
  exp_t         e;
  int           ea;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // RAM answers one cycle after the read strobe
  always @(posedge clk50m) if (mem_rd) mem_rdata <= ram[mem_addr];

  initial forever begin
    @(posedge clk50m);
    #2;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ~pix_ready;
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk50m) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", pix_valid, 1'b1);
        chk("stall_pix", pix, sp);
        chk("stall_line_end", line_end, sle);
        chk("stall_frame_end", frame_end, sfe);
      end
      stall_prev = pix_valid && !pix_ready;
      sp = pix; sle = line_end; sfe = frame_end;
      if (mem_rd) begin
        n_rd++;
        if (pix_valid) chk("rd_and_valid", 1'b1, 1'b0);
        if (aq.size() == 0) chk("unexpected_mem_rd", {27'd0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          ea = aq.pop_front();
          chk("mem_addr", {27'd0, mem_addr}, ea);
        end
      end
      if (pix_valid && pix_ready) begin
        n_xfer++;
        if (line_end) n_le++;
        if (frame_end) n_fe++;
        if (pq.size() == 0) chk("unexpected_pixel", 1'b1, 1'b0);
        else begin
          e = pq.pop_front();
          chk("pix", pix, e.p);
          chk("line_end", line_end, e.le);
          chk("frame_end", frame_end, e.fe);
        end
      end else if (!pix_valid && (line_end || frame_end)) begin
        chk("flag_without_valid", 1'b1, 1'b0);
      end
      if (busy) busy_cycles++;
    end
  end

  task automatic clear_counts();
    n_rd = 0; n_xfer = 0; n_le = 0; n_fe = 0; busy_cycles = 0;
  endtask

  task automatic fill_ram(input int mode);
    for (int a = 0; a < NW; a++) ram[a] = (mode == 1) ? 16'hA5A5 : W'($urandom);
  endtask

  task automatic start_frame();
    clear_counts();
    for (int a = 0; a < NW; a++) begin
      aq.push_back(a);
      for (int i = 0; i < W; i++) begin
        pq.push_back('{p: ram[a][i],
                       le: (i == W - 1) && (a % WPR == WPR - 1),
                       fe: (i == W - 1) && (a == NW - 1)});
      end
    end
    @(posedge clk50m); #2 start = 1'b1;
    @(posedge clk50m); #2 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk50m); #1;
      n++;
    end while (busy && n < budget);
    if (busy) chk("frame_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_words(input int words, input int budget);
    int n = 0;
    while (!(n_rd >= words && pix_valid) && n < budget) begin
      @(negedge clk50m); #1;
      n++;
    end
    if (n >= budget) chk("word_wait_timeout", 1'b1, 1'b0);
  endtask

  task automatic end_checks(input logic full_speed);
    chk("rd_pulses", n_rd, NW);
    chk("transfers", n_xfer, NW * W);
    chk("line_end_pulses", n_le, NW / WPR);
    chk("frame_end_pulses", n_fe, 1);
    chk("pix_queue_empty", pq.size(), 0);
    chk("addr_queue_empty", aq.size(), 0);
    chk("busy_after_frame", busy, 1'b0);
    chk("valid_after_frame", pix_valid, 1'b0);
    if (full_speed) chk("busy_cycles", busy_cycles, NW * (W + 2));
  endtask

  initial begin
    clear_counts();
    repeat (3) @(posedge clk50m);
    #1;
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    #1 rst_n = 1'b1;

    // single start, full-speed consumer, exact first-word timing
    ready_mode = 0;
    fill_ram(0);
    ram[0] = 16'h0001;
    start_frame();
    @(negedge clk50m); #1;
    chk("c1_mem_rd", mem_rd, 1'b1);
    chk("c1_mem_addr", mem_addr, 0);
    chk("c1_busy", busy, 1'b1);
    @(negedge clk50m); #1;
    chk("c2_mem_rd", mem_rd, 1'b0);
    chk("c2_pix_valid", pix_valid, 1'b0);
    @(negedge clk50m); #1;
    chk("c3_pix_valid", pix_valid, 1'b1);
    chk("c3_pix", pix, 1'b1);
    wait_idle(2000);
    end_checks(1'b1);

    // alternating back-pressure on a fixed pattern
    ready_mode = 1;
    fill_ram(1);
    start_frame();
    wait_idle(4000);
    end_checks(1'b0);

    // extra start mid-frame must be ignored
    ready_mode = 2;
    fill_ram(0);
    start_frame();
    wait_words(10, 2000);
    @(posedge clk50m); #2 start = 1'b1;
    @(posedge clk50m); #2 start = 1'b0;
    wait_idle(4000);
    end_checks(1'b0);

    // start coincident with the final transfer must be ignored
    ready_mode = 0;
    fill_ram(0);
    start_frame();
    begin
      int n = 0;
      while (!(pix_valid && frame_end) && n < 2000) begin
        @(negedge clk50m); #1;
        n++;
      end
      if (n >= 2000) chk("frame_end_timeout", 1'b1, 1'b0);
    end
    start = 1'b1;
    @(posedge clk50m); #2 start = 1'b0;
    wait_idle(100);
    end_checks(1'b1);
    repeat (5) @(negedge clk50m);
    #1;
    chk("late_start_busy", busy, 1'b0);
    chk("late_start_rd", n_rd, NW);

    // reset in the middle of a word aborts the frame
    ready_mode = 2;
    fill_ram(0);
    start_frame();
    wait_words(20, 3000);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_rd", mem_rd, 1'b0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_pix", pix, 1'b0);
    chk("abort_pix_valid", pix_valid, 1'b0);
    chk("abort_line_end", line_end, 1'b0);
    chk("abort_frame_end", frame_end, 1'b0);
    chk("abort_busy", busy, 1'b0);
    pq.delete();
    aq.delete();
    repeat (2) @(posedge clk50m);
    #2 rst_n = 1'b1;
    clear_counts();
    repeat (10) @(negedge clk50m);
    #1;
    chk("post_abort_xfers", n_xfer, 0);
    chk("post_abort_reads", n_rd, 0);

    // fresh frame after abort restarts at address 0
    fill_ram(0);
    start_frame();
    wait_idle(4000);
    end_checks(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
